// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: default widths and the jump-target table.
// No logic of its own; consumed by fetch_unit and its jump LUT.
// Table entries are signed integers, truncated to PC width where used.
package fetch_unit_pkg;

    // Default program-counter, opcode and jump-LUT index widths.
    localparam int PGM_CTR_W  = 8;
    localparam int OP_CDE_W   = 16;
    localparam int LUT_AW_DEF = 4;

    // How a redirect target is formed from a LUT entry.
    typedef enum logic {
        TGT_REL = 1'b0,   // brPc + sign-extended entry
        TGT_ABS = 1'b1    // entry used directly as the new PC
    } tgt_mode_e;

    // Jump-target table, kept next to the program images it serves.
    // Relative entries are two's-complement offsets.
    // Entry 4 is all ones once truncated, i.e. the last PC of the space.
    function automatic int jump_table(input int idx);
        case (idx)
            1:       return 20;
            2:       return 40;
            3:       return -5;
            4:       return -1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-target lookup, 2**LUT_AW entries of PC_W bits.
// Latency: zero cycles (pure combinational read).
// No flow control; the entry follows idx.
module fetch_unit_jump_lut
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PGM_CTR_W,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   entry
);

    // Read the constant table and truncate to PC width.
    always_comb begin
        entry = '0;
        entry = PC_W'(jump_table(int'(idx)));
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the PC into the ROM and registers the opcode into IF/ID.
// Latency: opcode at PC n appears in IF/ID one edge after PC=n; redirects cost one bubble.
// stall holds PC and IF/ID; flush bubbles IF/ID; once done is set only init is honoured.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W   = PGM_CTR_W,
    parameter int OP_W   = OP_CDE_W,
    parameter int LUT_AW = LUT_AW_DEF
) (
    input  logic              clk,
    input  logic              init,
    input  logic              stall,
    input  logic              flush,
    input  logic              brTaken,
    input  logic              jmpAbs,
    input  logic [LUT_AW-1:0] lutIdx,
    input  logic [PC_W-1:0]   brPc,
    input  logic [OP_W-1:0]   opCde,
    output logic [PC_W-1:0]   pgmCtr,
    output logic [OP_W-1:0]   ifInst,
    output logic [PC_W-1:0]   ifPc,
    output logic              ifValid,
    output logic              done
);

    // The halt opcode is all ones at whatever opcode width is configured.
    localparam logic [OP_W-1:0] HALT = '1;

    logic [PC_W-1:0] lut_val;
    logic [PC_W-1:0] target;
    logic            is_halt;
    tgt_mode_e       tgt_mode;

    logic [PC_W-1:0] pc_nxt;
    logic [OP_W-1:0] inst_nxt;
    logic [PC_W-1:0] if_pc_nxt;
    logic            valid_nxt;
    logic            done_nxt;

    fetch_unit_jump_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) jump_lut (
        .idx   (lutIdx),
        .entry (lut_val)
    );

    // Redirect target; the add is PC-wide so relative targets wrap naturally.
    always_comb begin
        tgt_mode = tgt_mode_e'(jmpAbs);
        is_halt  = (opCde == HALT);
        target   = lut_val;
        if (tgt_mode == TGT_REL) begin
            target = brPc + lut_val;
        end
    end

    // Next PC, IF/ID and done. Priority: done, redirect, stall, halt, sequential.
    // flush only affects IF/ID, and only a cleanly captured HALT raises done.
    always_comb begin
        pc_nxt    = pgmCtr;
        inst_nxt  = ifInst;
        if_pc_nxt = ifPc;
        valid_nxt = ifValid;
        done_nxt  = done;
        if (!done) begin
            if (brTaken) begin
                pc_nxt = target;
            end else if (!stall && !is_halt) begin
                pc_nxt = pgmCtr + PC_W'(1);
            end

            if (brTaken || flush) begin
                inst_nxt  = '0;
                if_pc_nxt = '0;
                valid_nxt = 1'b0;
            end else if (!stall) begin
                inst_nxt  = opCde;
                if_pc_nxt = pgmCtr;
                valid_nxt = 1'b1;
                done_nxt  = is_halt;
            end
        end
    end

    // State registers; init overrides everything, including done and stall.
    always_ff @(posedge clk) begin
        if (init) begin
            pgmCtr  <= '0;
            ifInst  <= '0;
            ifPc    <= '0;
            ifValid <= 1'b0;
            done    <= 1'b0;
        end else begin
            pgmCtr  <= pc_nxt;
            ifInst  <= inst_nxt;
            ifPc    <= if_pc_nxt;
            ifValid <= valid_nxt;
            done    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small combinational ROM model.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected values are hand-derived for PC_W=8, OP_W=16.
module tb_fetch_unit;

    localparam int PC_W   = 8;
    localparam int OP_W   = 16;
    localparam int LUT_AW = 4;

    logic              clk = 1'b0;
    logic              init;
    logic              stall;
    logic              flush;
    logic              brTaken;
    logic              jmpAbs;
    logic [LUT_AW-1:0] lutIdx;
    logic [PC_W-1:0]   brPc;
    logic [OP_W-1:0]   opCde;
    logic [PC_W-1:0]   pgmCtr;
    logic [OP_W-1:0]   ifInst;
    logic [PC_W-1:0]   ifPc;
    logic              ifValid;
    logic              done;

    // ROM image: 0x5A in the high byte, the address in the low byte,
    // except a HALT (all ones) at halt_addr when halt_en is set.
    logic            halt_en;
    logic [PC_W-1:0] halt_addr;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_unit dut (
        .clk     (clk),
        .init    (init),
        .stall   (stall),
        .flush   (flush),
        .brTaken (brTaken),
        .jmpAbs  (jmpAbs),
        .lutIdx  (lutIdx),
        .brPc    (brPc),
        .opCde   (opCde),
        .pgmCtr  (pgmCtr),
        .ifInst  (ifInst),
        .ifPc    (ifPc),
        .ifValid (ifValid),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign opCde = (halt_en && pgmCtr == halt_addr) ? 16'hFFFF : {8'h5A, pgmCtr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic branch(input logic abs, input logic [LUT_AW-1:0] idx, input logic [PC_W-1:0] bpc);
        brTaken = 1'b1;
        jmpAbs  = abs;
        lutIdx  = idx;
        brPc    = bpc;
        tick();
        brTaken = 1'b0;
        jmpAbs  = 1'b0;
        lutIdx  = '0;
        brPc    = '0;
    endtask

    initial begin
        init = 1'b1; stall = 1'b0; flush = 1'b0; brTaken = 1'b0;
        jmpAbs = 1'b0; lutIdx = '0; brPc = '0;
        halt_en = 1'b0; halt_addr = '0;

        // Reset state
        tick(); tick();
        check("rst_pc",    32'(pgmCtr),  32'd0);
        check("rst_inst",  32'(ifInst),  32'd0);
        check("rst_ifpc",  32'(ifPc),    32'd0);
        check("rst_valid", 32'(ifValid), 32'd0);
        check("rst_done",  32'(done),    32'd0);

        // Free run
        init = 1'b0;
        check("run0_pc",    32'(pgmCtr),  32'd0);
        check("run0_valid", 32'(ifValid), 32'd0);
        tick();
        check("run1_pc",    32'(pgmCtr),  32'd1);
        check("run1_ifpc",  32'(ifPc),    32'd0);
        check("run1_valid", 32'(ifValid), 32'd1);
        check("run1_inst",  32'(ifInst),  32'h5A00);
        tick();
        check("run2_pc",   32'(pgmCtr), 32'd2);
        check("run2_ifpc", 32'(ifPc),   32'd1);
        tick();
        check("run3_pc",   32'(pgmCtr), 32'd3);
        check("run3_ifpc", 32'(ifPc),   32'd2);
        for (int i = 0; i < 4; i++) tick();
        check("run7_pc",   32'(pgmCtr), 32'd7);
        check("run7_ifpc", 32'(ifPc),   32'd6);

        // Absolute jump, lut[2] = 40
        branch(1'b1, 4'd2, 8'd0);
        check("abs_pc",    32'(pgmCtr),  32'd40);
        check("abs_valid", 32'(ifValid), 32'd0);
        check("abs_inst",  32'(ifInst),  32'd0);
        tick();
        check("abs_ifpc",   32'(ifPc),    32'd40);
        check("abs_valid2", 32'(ifValid), 32'd1);
        check("abs_pc2",    32'(pgmCtr),  32'd41);

        // Relative branch, lut[3] = -5
        branch(1'b0, 4'd3, 8'd12);
        check("rel_pc", 32'(pgmCtr), 32'd7);
        branch(1'b0, 4'd3, 8'd2);
        check("rel_wrap_pc", 32'(pgmCtr), 32'd253);
        tick();
        check("rel_wrap_ifpc", 32'(ifPc), 32'd253);

        // Stall at PC 5 with IF/ID holding PC 4
        branch(1'b0, 4'd3, 8'd9);
        check("to4_pc", 32'(pgmCtr), 32'd4);
        tick();
        check("pre_stall_pc", 32'(pgmCtr), 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc",    32'(pgmCtr),  32'd5);
            check("stall_ifpc",  32'(ifPc),    32'd4);
            check("stall_inst",  32'(ifInst),  32'h5A04);
            check("stall_valid", 32'(ifValid), 32'd1);
        end
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 32'(ifValid), 32'd0);
        check("flush_stall_inst",  32'(ifInst),  32'd0);
        check("flush_stall_pc",    32'(pgmCtr),  32'd5);
        flush = 1'b0; stall = 1'b0;
        tick();
        check("resume_pc",    32'(pgmCtr),  32'd6);
        check("resume_ifpc",  32'(ifPc),    32'd5);
        check("resume_valid", 32'(ifValid), 32'd1);

        // HALT at address 9
        halt_en = 1'b1; halt_addr = 8'd9;
        tick(); tick(); tick();
        check("pre_halt_pc",   32'(pgmCtr), 32'd9);
        check("pre_halt_done", 32'(done),   32'd0);
        tick();
        check("halt_done", 32'(done),   32'd1);
        check("halt_ifpc", 32'(ifPc),   32'd9);
        check("halt_inst", 32'(ifInst), 32'hFFFF);
        check("halt_pc",   32'(pgmCtr), 32'd9);
        flush = 1'b1;
        branch(1'b1, 4'd2, 8'd0);
        flush = 1'b0;
        check("done_ign_pc",    32'(pgmCtr),  32'd9);
        check("done_ign_valid", 32'(ifValid), 32'd1);
        check("done_ign_done",  32'(done),    32'd1);
        init = 1'b1;
        tick();
        init = 1'b0;
        check("reinit_pc",    32'(pgmCtr),  32'd0);
        check("reinit_inst",  32'(ifInst),  32'd0);
        check("reinit_ifpc",  32'(ifPc),    32'd0);
        check("reinit_valid", 32'(ifValid), 32'd0);
        check("reinit_done",  32'(done),    32'd0);

        // PC wrap via jump to the last address
        halt_en = 1'b0;
        branch(1'b1, 4'd4, 8'd0);
        check("wrap_top_pc", 32'(pgmCtr), 32'd255);
        tick();
        check("wrap_pc",   32'(pgmCtr), 32'd0);
        check("wrap_ifpc", 32'(ifPc),   32'd255);

        // Redirect in the same cycle a HALT is fetched
        halt_en = 1'b1; halt_addr = 8'd1;
        tick();
        check("brhalt_pre_pc", 32'(pgmCtr), 32'd1);
        branch(1'b1, 4'd1, 8'd0);
        check("brhalt_pc",    32'(pgmCtr),  32'd20);
        check("brhalt_done",  32'(done),    32'd0);
        check("brhalt_valid", 32'(ifValid), 32'd0);
        tick();
        check("brhalt_pc2",   32'(pgmCtr), 32'd21);
        check("brhalt_ifpc",  32'(ifPc),   32'd20);
        check("brhalt_done2", 32'(done),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the program counter into the instruction ROM and registers the returned opcode into the IF/ID pipeline register. It sits directly upstream of the ROM and downstream of the execute-stage branch resolution. It handles sequential fetch, branch/jump redirects through a small target LUT, stall, flush and program halt. The ROM read is combinational, so one fetch completes per cycle.

## Interface
Parameters:
- PC_W, default `pgmCtrW: program-counter width.
- OP_W, default `opCdeW: opcode width.
- LUT_AW, default 4: jump-LUT index width (2**LUT_AW entries).

Ports:
- clk, input, 1: the single clock. All state updates on rising edge.
- init, input, 1: synchronous, active-high reset.
- stall, input, 1: hold the PC and IF/ID contents.
- flush, input, 1: load a bubble into IF/ID.
- brTaken, input, 1: redirect request from execute.
- jmpAbs, input, 1: 1 = absolute target, 0 = PC-relative target.
- lutIdx, input, LUT_AW: jump-LUT index.
- brPc, input, PC_W: PC of the redirecting instruction.
- opCde, input, OP_W: opcode returned by the ROM for pgmCtr.
- pgmCtr, output, PC_W: current PC, driven to the ROM.
- ifInst, output, OP_W: IF/ID opcode.
- ifPc, output, PC_W: IF/ID PC.
- ifValid, output, 1: IF/ID holds a real instruction.
- done, output, 1: a halt instruction has been fetched.

## Operation
- State: PC register, IF/ID register (ifInst, ifPc, ifValid), done flag.
- pgmCtr is the PC register output directly, with no logic after the flop.
- Next-PC priority (highest first):
  - init: PC=0.
  - done=1: hold.
  - brTaken: PC=target.
  - stall: hold.
  - opCde==HALT: hold.
  - otherwise: PC+1.
- Target calculation:
  - jmpAbs=1: target = lut[lutIdx], zero-extended.
  - jmpAbs=0: target = brPc + sign-extended lut[lutIdx].
  - Result is truncated to PC_W, so it wraps modulo 2**PC_W.
- PC+1 wraps from 2**PC_W-1 to 0.
- IF/ID update, same priority order:
  - init: clear all fields to 0.
  - done: hold.
  - brTaken or flush: ifValid=0, ifInst=0, ifPc=0.
  - stall: hold.
  - otherwise: ifInst=opCde, ifPc=PC, ifValid=1.
- flush without brTaken does not alter the PC. It is still subject to stall.
- If flush and stall are both asserted, flush wins for IF/ID and stall wins for the PC.
- Halt:
  - When opCde==HALT is captured into IF/ID (valid, not stalled, not redirected), done rises on the same edge.
  - done stays high until init.
  - While done=1, all inputs except init are ignored.
- brTaken together with an opCde==HALT fetch: the redirect wins, the halt is discarded, and done stays 0.

## Timing
- Reset values: pgmCtr=0, ifInst=0, ifPc=0, ifValid=0, done=0.
- Fetch latency:
  - The opcode at PC n appears on ifInst one edge after PC=n.
  - The first valid instruction (PC 0) is in IF/ID one cycle after init deasserts.
- Redirect penalty:
  - The edge that samples brTaken loads the target PC and bubbles IF/ID.
  - The target instruction is valid in IF/ID on the next edge.
- Asserting init mid-operation (including while stalled or done) takes effect on the next edge, regardless of other inputs.
- No combinational path exists from any input to pgmCtr.

## Structure
- Shared definitions file additions: `HALT opcode constant (all ones, OP_W bits) and the LUT_AW default. Existing `pgmCtrW and `opCdeW are reused.
- Sub-module jump_lut:
  - Combinational, 2**LUT_AW entries of PC_W bits.
  - Contents are a constant case table defined alongside the program images.
  - Relative entries are two's-complement offsets.
- fetch_unit holds the PC, IF/ID and done flops plus the next-PC mux.

## Test plan
- Reset then free-run (no stall or branch, ROM with no HALT in 0..3): pgmCtr=0,1,2,3 on successive cycles; ifPc=0,1,2 lagging by one; ifValid=0 in the first cycle, then 1.
- Absolute jump with lut[2]=40: assert brTaken, jmpAbs=1, lutIdx=2 at PC=7 → next pgmCtr=40, ifValid=0 for one cycle, then ifPc=40.
- Relative branch with lut[3]=-5 and brPc=12 → target 7. Also brPc=2 with offset -5 → wraps to 2**PC_W-3.
- Stall held 3 cycles at PC=5 → pgmCtr stays 5 and IF/ID unchanged. flush with stall → ifValid=0 and pgmCtr still 5.
- HALT at address 9 → done=1 on the edge capturing ifPc=9; pgmCtr stays 9; a later brTaken is ignored; init returns all outputs to reset values.
- PC wrap: preload PC to 2**PC_W-1 via jump → next pgmCtr=0. brTaken in the same cycle HALT is fetched → done stays 0.
